alu_input_loader: RTL and testbench
===================================

ALU_INPUT_LOADER -- requirements
Module: alu_input_loader

Interface
REQ-001 Parameter SIZE, default 8: operand and result width in bits.
REQ-002 Parameter DB_CYCLES, default 4: consecutive stable clocks a synchronized button must hold before it is accepted.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_sw  input  SIZE  switch bus; the data source for every load.
REQ-006 i_btn_a / i_btn_b / i_btn_op  input  1 each  asynchronous push buttons that load A, B and opcode.
REQ-007 i_res_alu  input  SIZE  signed result returned by the ALU.
REQ-008 i_carry_alu  input  1  carry returned by the ALU.
REQ-009 o_a_alu / o_b_alu  output  SIZE each  registered signed operands driven to the ALU.
REQ-010 o_opcode_alu  output  6  registered opcode, taken from i_sw[5:0].
REQ-011 o_res_led  output  SIZE  captured result.
REQ-012 o_carry_led  output  1  captured carry.
REQ-013 o_valid  output  1  high while o_res_led/o_carry_led reflect the current operands.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then debounce, then rising-edge detection, which produces a one-cycle load strobe.
REQ-015 The load strobe SHALL assert on the 3+DB_CYCLES-th clock after the raw input rises and then stays stable; the target register SHALL update on the following edge.
REQ-016 Any toggle before DB_CYCLES stable cycles SHALL restart the count; a held button SHALL yield exactly one strobe; release SHALL yield none.
REQ-017 Strobe A SHALL load o_a_alu<=i_sw, strobe B SHALL load o_b_alu<=i_sw, and strobe OP SHALL load o_opcode_alu<=i_sw[5:0]; the opcode SHALL NOT be range-checked.
REQ-018 Simultaneous strobes SHALL all load in the same cycle, from the same i_sw value.
REQ-019 Per-register flags loaded_a/b/op SHALL set on a load and clear only on reset.
REQ-020 FSM states SHALL be IDLE, SETTLE, CAPTURE and SHOW.
REQ-021 IDLE->SETTLE on the cycle after all three flags are set.
REQ-022 SETTLE->CAPTURE after one clock.
REQ-023 In CAPTURE, o_res_led<=i_res_alu and o_carry_led<=i_carry_alu, then ->SHOW.
REQ-024 SHOW SHALL set o_valid=1; o_valid SHALL be 0 in every other state.
REQ-025 Any load strobe in SETTLE, CAPTURE or SHOW SHALL return the FSM to SETTLE, with capture suppressed that cycle; o_res_led SHALL hold its old value until the next CAPTURE.
REQ-026 Latency: o_valid SHALL rise 3 clocks after the completing load edge.

Reset
REQ-027 Reset SHALL clear all outputs, flags, synchronizers and debounce counters to 0 and set the FSM to IDLE, immediately and independent of i_clk.
REQ-028 Reset asserted mid-debounce or mid-capture SHALL discard the pending strobe.

Configuration
REQ-029 Macro LOADER_DEBOUNCE_EN, when defined, SHALL include the DB_CYCLES debounce stage.
REQ-030 When LOADER_DEBOUNCE_EN is undefined, the strobe SHALL assert 3 clocks after the raw input rises (synchronizer plus edge detection only), and DB_CYCLES SHALL be ignored.

Structure
REQ-031 Shared package alu_pkg SHALL hold the opcode constants (ADD 6'b100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111) and the FSM state encoding.
REQ-032 Sub-module btn_debounce (synchronizer, debounce, edge) SHALL be instantiated three times.

Verification
REQ-033 Debounce on, DB_CYCLES=4, ALU attached: sw=5 press A; sw=3 press B; sw=6'b100000 press OP -> o_a=5, o_b=3, o_valid=1 three clocks later, o_res_led=8.
REQ-034 Button bouncing 1-0-1 at 2-cycle intervals, then held 10 cycles -> exactly one strobe, 7 clocks after the final rise.
REQ-035 In SHOW, sw=1 and press B -> o_valid low the next cycle, high 3 clocks after the load, o_res_led=6 (ADD).
REQ-036 A and OP pressed in the same cycle with sw=8'h22 -> o_a_alu=8'h22, o_opcode_alu=6'h22, o_b_alu unchanged.
REQ-037 i_rst_n low for 1 ns mid-debounce and during SHOW -> all outputs 0 asynchronously, FSM IDLE, no strobe after release.
REQ-038 LOADER_DEBOUNCE_EN undefined -> strobe exactly 3 clocks after the raw rise, and a bounce produces multiple loads.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode constants and loader FSM state encoding shared by the loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SHOW    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : Push-button conditioner: 2-flop synchronizer, optional debounce
//          (macro LOADER_DEBOUNCE_EN), rising-edge detect -> one-cycle strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_strobe
);

`ifdef LOADER_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic sync1_q;
    logic sync2_q;
    logic level_dly_q;
    logic strobe_q;
    logic w_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_dly_q <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            sync1_q     <= i_btn;
            sync2_q     <= sync1_q;
            level_dly_q <= w_level;
            strobe_q    <= w_level & ~level_dly_q;
        end
    end

    generate
        if (DB_ON && DB_CYCLES > 0) begin : g_debounce
            localparam int CW = $clog2(DB_CYCLES + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stable_q;
            logic          stable_d;

            // Count consecutive cycles that disagree with the accepted level;
            // any agreement (a bounce back) restarts the count.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync2_q == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    cnt_d    = '0;
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign w_level = stable_q;
        end else begin : g_bypass
            assign w_level = sync2_q;
        end
    endgenerate

    assign o_strobe = strobe_q;

endmodule

`default_nettype wire

// File: rtl/alu_input_loader.sv
// ============================================================================
// Module : alu_input_loader
// Brief  : Loads ALU operands/opcode from switches on button strobes and
//          captures the ALU result. Debounce stage under LOADER_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_input_loader
    import alu_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [SIZE-1:0]        i_sw,
    input  logic                   i_btn_a,
    input  logic                   i_btn_b,
    input  logic                   i_btn_op,
    input  logic signed [SIZE-1:0] i_res_alu,
    input  logic                   i_carry_alu,
    output logic signed [SIZE-1:0] o_a_alu,
    output logic signed [SIZE-1:0] o_b_alu,
    output logic [5:0]             o_opcode_alu,
    output logic signed [SIZE-1:0] o_res_led,
    output logic                   o_carry_led,
    output logic                   o_valid
);

    logic w_stb_a;
    logic w_stb_b;
    logic w_stb_op;
    logic w_any_stb;
    logic w_capture;

    logic signed [SIZE-1:0] a_q;
    logic signed [SIZE-1:0] b_q;
    logic [5:0]             op_q;
    logic signed [SIZE-1:0] res_q;
    logic                   carry_q;
    logic                   loaded_a_q;
    logic                   loaded_b_q;
    logic                   loaded_op_q;
    state_e                 state_q;
    state_e                 state_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a), .o_strobe(w_stb_a)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b), .o_strobe(w_stb_b)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_op (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op), .o_strobe(w_stb_op)
    );

    assign w_any_stb = w_stb_a | w_stb_b | w_stb_op;

    // A new load invalidates the result in flight: restart the settle window
    // and skip this cycle's capture so the old result stays on the LEDs.
    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        case (state_q)
            ST_IDLE:    if (loaded_a_q && loaded_b_q && loaded_op_q) state_d = ST_SETTLE;
            ST_SETTLE:  state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d   = ST_SHOW;
                w_capture = 1'b1;
            end
            ST_SHOW:    state_d = ST_SHOW;
            default:    state_d = ST_IDLE;
        endcase
        if (w_any_stb && state_q != ST_IDLE) begin
            state_d   = ST_SETTLE;
            w_capture = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            loaded_a_q  <= 1'b0;
            loaded_b_q  <= 1'b0;
            loaded_op_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_stb_a) begin
                a_q        <= i_sw;
                loaded_a_q <= 1'b1;
            end
            if (w_stb_b) begin
                b_q        <= i_sw;
                loaded_b_q <= 1'b1;
            end
            if (w_stb_op) begin
                op_q        <= i_sw[5:0];
                loaded_op_q <= 1'b1;
            end
            if (w_capture) begin
                res_q   <= i_res_alu;
                carry_q <= i_carry_alu;
            end
        end
    end

    assign o_a_alu      = a_q;
    assign o_b_alu      = b_q;
    assign o_opcode_alu = op_q;
    assign o_res_led    = res_q;
    assign o_carry_led  = carry_q;
    assign o_valid      = (state_q == ST_SHOW);

endmodule

`default_nettype wire

// File: tb/tb_alu_input_loader.sv
// ============================================================================
// Module : tb_alu_input_loader
// Brief  : Self-checking bench for alu_input_loader with a behavioural ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_input_loader;
    import alu_pkg::*;

    localparam int SIZE = 8;
    localparam int DB   = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT  = 3 + DB;
`else
    localparam int LAT  = 3;
`endif

    typedef struct {
        int         sel;
        logic [7:0] val;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SIZE-1:0]   sw;
    logic              btn_a, btn_b, btn_op;
    logic [SIZE-1:0]   res_alu;
    logic              carry_alu;
    logic signed [SIZE-1:0] a_alu, b_alu, res_led;
    logic [5:0]        op_alu;
    logic              carry_led, valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [7:0] m_a, m_b, m_op;

    always #5 clk = ~clk;

    alu_input_loader #(.SIZE(SIZE), .DB_CYCLES(DB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw),
        .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
        .i_res_alu(res_alu), .i_carry_alu(carry_alu),
        .o_a_alu(a_alu), .o_b_alu(b_alu), .o_opcode_alu(op_alu),
        .o_res_led(res_led), .o_carry_led(carry_led), .o_valid(valid)
    );

    // Behavioural ALU closing the loop
    always_comb begin
        res_alu   = '0;
        carry_alu = 1'b0;
        case (op_alu)
            OP_ADD: {carry_alu, res_alu} = {1'b0, a_alu} + {1'b0, b_alu};
            OP_SUB: {carry_alu, res_alu} = {1'b0, a_alu} - {1'b0, b_alu};
            OP_AND: res_alu = a_alu & b_alu;
            OP_OR:  res_alu = a_alu | b_alu;
            OP_XOR: res_alu = a_alu ^ b_alu;
            OP_NOR: res_alu = ~(a_alu | b_alu);
            OP_SRA: res_alu = a_alu >>> b_alu;
            OP_SRL: res_alu = a_alu >> b_alu;
            default: res_alu = '0;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int sel, input logic v);
        case (sel)
            0:       btn_a  = v;
            1:       btn_b  = v;
            default: btn_op = v;
        endcase
    endtask

    function automatic logic [7:0] reg_of(input int sel);
        case (sel)
            0:       return a_alu;
            1:       return b_alu;
            default: return {2'b00, op_alu};
        endcase
    endfunction

    function automatic logic [7:0] model_of(input int sel);
        case (sel)
            0:       return m_a;
            1:       return m_b;
            default: return m_op;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; sw = '0; btn_a = 0; btn_b = 0; btn_op = 0;
        m_a = '0; m_b = '0; m_op = '0;
        #2;
        checks++;
        if ({a_alu, b_alu, op_alu, res_led, carry_led} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h %h %b want all 0", a_alu, b_alu, op_alu, res_led, carry_led);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_load_sequence();
        logic [7:0] vals[3];
        exp_t e;
        vals = '{8'd5, 8'd3, {2'b00, OP_ADD}};
        for (int i = 0; i < 3; i++) begin
            sw = vals[i];
            sb.push_back('{i, vals[i]});
            set_btn(i, 1'b1);
            tick(LAT);
            checks++;
            if (reg_of(i) !== model_of(i)) begin
                errors++;
                $display("FAIL seq_preload%0d: got %h want %h", i, reg_of(i), model_of(i));
            end
            tick(1);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (reg_of(e.sel) !== e.val) begin
                    errors++;
                    $display("FAIL seq_load%0d: got %h want %h", e.sel, reg_of(e.sel), e.val);
                end
                if (e.sel == 0) m_a = e.val; else if (e.sel == 1) m_b = e.val; else m_op = e.val;
            end
            if (i < 2) begin
                set_btn(i, 1'b0);
                tick(LAT + 2);
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_valid_early%0d: got %b want 0", i, valid);
                end
            end
        end
        tick(2);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_valid_lat2: got %b want 0", valid);
        end
        tick(1);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_valid_lat3: got %b want 1", valid);
        end
        checks++;
        if (res_led !== 8'sd8 || carry_led !== 1'b0) begin
            errors++;
            $display("FAIL seq_result: got %h/%b want 08/0", res_led, carry_led);
        end
        btn_op = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_reload_in_show();
        exp_t e;
        sw = 8'd1;
        sb.push_back('{1, 8'd1});
        btn_b = 1'b1;
        tick(LAT);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL reload_valid_before: got %b want 1", valid);
        end
        tick(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (reg_of(e.sel) !== e.val) begin
                errors++;
                $display("FAIL reload_load%0d: got %h want %h", e.sel, reg_of(e.sel), e.val);
            end
            m_b = e.val;
        end
        checks++;
        if (valid !== 1'b0 || res_led !== 8'sd8) begin
            errors++;
            $display("FAIL reload_drop: got valid %b res %h want 0/08", valid, res_led);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reload_settle: got %b want 0", valid);
        end
        tick(1);
        checks++;
        if (valid !== 1'b1 || res_led !== 8'sd6) begin
            errors++;
            $display("FAIL reload_show: got valid %b res %h want 1/06", valid, res_led);
        end
        sw = 8'hF0;
        tick(LAT + 3);
        checks++;
        if (b_alu !== m_b || valid !== 1'b1) begin
            errors++;
            $display("FAIL held_single: got b %h valid %b want %h/1", b_alu, valid, m_b);
        end
        btn_b = 1'b0;
        tick(LAT + 3);
        checks++;
        if (b_alu !== m_b || valid !== 1'b1) begin
            errors++;
            $display("FAIL release_none: got b %h valid %b want %h/1", b_alu, valid, m_b);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        sw = 8'h22;
        sb.push_back('{0, 8'h22});
        sb.push_back('{2, 8'h22});
        btn_a = 1'b1; btn_op = 1'b1;
        tick(LAT);
        checks++;
        if (a_alu !== m_a || {2'b00, op_alu} !== m_op) begin
            errors++;
            $display("FAIL simul_pre: got %h %h want %h %h", a_alu, op_alu, m_a, m_op);
        end
        tick(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (reg_of(e.sel) !== e.val) begin
                errors++;
                $display("FAIL simul_load%0d: got %h want %h", e.sel, reg_of(e.sel), e.val);
            end
            if (e.sel == 0) m_a = e.val; else m_op = e.val;
        end
        checks++;
        if (b_alu !== m_b) begin
            errors++;
            $display("FAIL simul_b_kept: got %h want %h", b_alu, m_b);
        end
        btn_a = 1'b0; btn_op = 1'b0;
        tick(LAT + 2);
        checks++;
        if (valid !== 1'b1 || res_led !== 8'sh21 || carry_led !== 1'b0) begin
            errors++;
            $display("FAIL simul_sub: got %b %h %b want 1/21/0", valid, res_led, carry_led);
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        logic [7:0] mid;
        sw = 8'h31;
`ifndef LOADER_DEBOUNCE_EN
        sb.push_back('{0, 8'h31});
`endif
        btn_a = 1'b1; tick(2);
        btn_a = 1'b0; tick(2);
        btn_a = 1'b1;
        tick(1);
`ifdef LOADER_DEBOUNCE_EN
        mid = m_a;
`else
        mid = 8'h31;
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front();
            m_a = e.val;
        end
        checks++;
        if (a_alu !== mid) begin
            errors++;
            $display("FAIL bounce_first: got %h want %h", a_alu, mid);
        end
        sw = 8'h4C;
        sb.push_back('{0, 8'h4C});
        tick(LAT - 1);
        checks++;
        if (a_alu !== mid) begin
            errors++;
            $display("FAIL bounce_pre_final: got %h want %h", a_alu, mid);
        end
        tick(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (reg_of(e.sel) !== e.val) begin
                errors++;
                $display("FAIL bounce_final: got %h want %h", reg_of(e.sel), e.val);
            end
            m_a = e.val;
        end
        sw = 8'h99;
        tick(6);
        checks++;
        if (a_alu !== m_a) begin
            errors++;
            $display("FAIL bounce_held: got %h want %h", a_alu, m_a);
        end
        btn_a = 1'b0;
        tick(LAT + 4);
    endtask

    task automatic test_async_reset();
        exp_t e;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_show: got %b want 1", valid);
        end
        sw = 8'h77;
        btn_a = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_alu, b_alu, op_alu, res_led, carry_led, valid} !== '0) begin
            errors++;
            $display("FAIL areset_async: got %h %h %h %h %b %b want all 0", a_alu, b_alu, op_alu, res_led, carry_led, valid);
        end
        btn_a = 1'b0;
        rst_n = 1'b1;
        m_a = '0; m_b = '0; m_op = '0;
        sb.delete();
        tick(LAT + 4);
        checks++;
        if (a_alu !== m_a || valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_no_strobe: got a %h valid %b want 00/0", a_alu, valid);
        end
        sw = 8'h02;
        sb.push_back('{1, 8'h02});
        btn_b = 1'b1;
        tick(LAT + 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (reg_of(e.sel) !== e.val) begin
                errors++;
                $display("FAIL areset_reload: got %h want %h", reg_of(e.sel), e.val);
            end
            m_b = e.val;
        end
        btn_b = 1'b0;
        tick(6);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_flags: got %b want 0", valid);
        end
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_reload_in_show();
        test_simultaneous();
        test_bounce();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
